// File: rtl/debounce_edge.sv
// Synchroniser + glitch filter for a raw asynchronous input: clean level, complement and rise/fall pulses.
// Build option DEBOUNCE_EDGE_CNT_EN adds an 8-bit rising-edge event counter on evt_cnt.
module debounce_edge #(
  parameter int   CNT_W         = 4,
  parameter int   STABLE_CYCLES = 8,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       en,
  output logic       dout,
  output logic       doutbar,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] evt_cnt
);

  // STABLE: dout settled.  CHECK: a candidate level is being qualified.
  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_CHECK  = 1'b1;

  // STABLE_CYCLES must lie in 1..2^CNT_W-1 so the counter never wraps.
  localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(STABLE_CYCLES);

  logic             r_s1;
  logic             r_s2;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;
  logic             r_doutbar;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;

  logic             w_diff;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_commit;

  assign w_diff    = (r_s2 != r_dout);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (en && w_diff) begin
          if (STABLE_CYCLES == 1) begin
            w_commit = 1'b1;
          end else begin
            w_state_nxt = ST_CHECK;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_CHECK: begin
        // With en low the candidate and its count are frozen.
        if (en) begin
          if (!w_diff) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == SC_LAST) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= RST_VAL;
      r_s2      <= RST_VAL;
      r_state   <= ST_STABLE;
      r_cnt     <= '0;
      r_dout    <= RST_VAL;
      r_doutbar <= ~RST_VAL;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_s1    <= din;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == ST_CHECK);
      r_rise  <= w_commit & r_s2;
      r_fall  <= w_commit & ~r_s2;
      if (w_commit) begin
        r_dout    <= r_s2;
        r_doutbar <= ~r_s2;
      end
    end
  end

`ifdef DEBOUNCE_EDGE_CNT_EN
  logic [7:0] r_evt_cnt;

  // Counts cycles with rise asserted; wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_cnt <= 8'h00;
    end else if (r_rise) begin
      r_evt_cnt <= r_evt_cnt + 8'd1;
    end
  end

  assign evt_cnt = r_evt_cnt;
`else
  assign evt_cnt = 8'h00;
`endif

  assign dout    = r_dout;
  assign doutbar = r_doutbar;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign busy    = r_busy;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: instance A (STABLE_CYCLES=8, RST_VAL=0) and B (STABLE_CYCLES=1, RST_VAL=1),
// both checked every cycle against a run-length reference model, plus vector table and corner sequences.
module tb_debounce_edge;

  localparam int SC_A = 8;
  localparam int SC_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_din, a_en;
  logic       a_dout, a_doutbar, a_rise, a_fall, a_busy;
  logic [7:0] a_evt;
  logic       b_rst, b_din, b_en;
  logic       b_dout, b_doutbar, b_rise, b_fall, b_busy;
  logic [7:0] b_evt;

  debounce_edge #(.CNT_W(4), .STABLE_CYCLES(SC_A), .RST_VAL(1'b0)) u_a (
    .clk(clk), .rst(a_rst), .din(a_din), .en(a_en),
    .dout(a_dout), .doutbar(a_doutbar), .rise(a_rise), .fall(a_fall),
    .busy(a_busy), .evt_cnt(a_evt)
  );

  debounce_edge #(.CNT_W(4), .STABLE_CYCLES(SC_B), .RST_VAL(1'b1)) u_b (
    .clk(clk), .rst(b_rst), .din(b_din), .en(b_en),
    .dout(b_dout), .doutbar(b_doutbar), .rise(b_rise), .fall(b_fall),
    .busy(b_busy), .evt_cnt(b_evt)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the new level is accepted once it has been seen on sc consecutive
  // qualified samples of the 2-flop-delayed input; any qualified sample equal to dout resets the run.
  typedef struct {
    logic [1:0] pipe;
    logic       dout;
    int         run;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] evt;
  } model_t;

  function automatic model_t mstep(model_t m, int sc, logic rv, logic r, logic d, logic e);
    model_t n = m;
    logic   s2;
    if (r) begin
      n.pipe = {rv, rv};
      n.dout = rv;
      n.run  = 0;
      n.rise = 1'b0;
      n.fall = 1'b0;
      n.busy = 1'b0;
      n.evt  = 8'h00;
      return n;
    end
    s2     = m.pipe[1];
    n.pipe = {m.pipe[0], d};
`ifdef DEBOUNCE_EDGE_CNT_EN
    if (m.rise) n.evt = m.evt + 8'd1;
`endif
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (e) begin
      if (s2 != m.dout) begin
        n.run = m.run + 1;
        if (n.run == sc) begin
          n.dout = s2;
          n.rise = s2;
          n.fall = ~s2;
          n.run  = 0;
        end
      end else begin
        n.run = 0;
      end
    end
    n.busy = (n.run != 0);
    return n;
  endfunction

  model_t ma, mb;

  // One clock: both models step on the edge, both DUTs are compared 1 unit later.
  task automatic tick();
    @(posedge clk);
    ma = mstep(ma, SC_A, 1'b0, a_rst, a_din, a_en);
    mb = mstep(mb, SC_B, 1'b1, b_rst, b_din, b_en);
    #1;
    chk("a_dout",    {7'd0, a_dout},    {7'd0, ma.dout});
    chk("a_doutbar", {7'd0, a_doutbar}, {7'd0, ~ma.dout});
    chk("a_rise",    {7'd0, a_rise},    {7'd0, ma.rise});
    chk("a_fall",    {7'd0, a_fall},    {7'd0, ma.fall});
    chk("a_busy",    {7'd0, a_busy},    {7'd0, ma.busy});
    chk("a_evt",     a_evt,             ma.evt);
    chk("b_dout",    {7'd0, b_dout},    {7'd0, mb.dout});
    chk("b_doutbar", {7'd0, b_doutbar}, {7'd0, ~mb.dout});
    chk("b_rise",    {7'd0, b_rise},    {7'd0, mb.rise});
    chk("b_fall",    {7'd0, b_fall},    {7'd0, mb.fall});
    chk("b_busy",    {7'd0, b_busy},    {7'd0, mb.busy});
    chk("b_evt",     b_evt,             mb.evt);
  endtask

  task automatic reset_a(input logic d);
    a_rst = 1'b1; a_din = d; a_en = 1'b1;
    tick(); tick();
    a_rst = 1'b0;
    tick(); tick(); tick();
  endtask

  typedef struct {
    logic rst, din, en;
    logic dout, rise, fall, busy;
  } vec_t;

  vec_t tv[14];

  initial begin
    int   cnt;
    int   busy_n;
    logic seen_busy, seen_pulse, moved;

    a_rst = 1'b1; a_din = 1'b0; a_en = 1'b1;
    b_rst = 1'b1; b_din = 1'b1; b_en = 1'b1;
    ma = '{pipe: 2'b00, dout: 1'b0, run: 0, rise: 1'b0, fall: 1'b0, busy: 1'b0, evt: 8'h00};
    mb = '{pipe: 2'b11, dout: 1'b1, run: 0, rise: 1'b0, fall: 1'b0, busy: 1'b0, evt: 8'h00};

    // Clean step on A: two reset cycles, din rises at row 3, dout/rise at row 12.
    for (int i = 0; i < 14; i++) begin
      tv[i].rst  = (i < 2);
      tv[i].din  = (i >= 3);
      tv[i].en   = 1'b1;
      tv[i].dout = (i >= 12);
      tv[i].rise = (i == 12);
      tv[i].fall = 1'b0;
      tv[i].busy = (i >= 5) && (i <= 11);
    end
    for (int i = 0; i < 14; i++) begin
      a_rst = tv[i].rst; a_din = tv[i].din; a_en = tv[i].en;
      tick();
      chk($sformatf("tv%0d_dout", i),    {7'd0, a_dout},    {7'd0, tv[i].dout});
      chk($sformatf("tv%0d_doutbar", i), {7'd0, a_doutbar}, {7'd0, ~tv[i].dout});
      chk($sformatf("tv%0d_rise", i),    {7'd0, a_rise},    {7'd0, tv[i].rise});
      chk($sformatf("tv%0d_fall", i),    {7'd0, a_fall},    {7'd0, tv[i].fall});
      chk($sformatf("tv%0d_busy", i),    {7'd0, a_busy},    {7'd0, tv[i].busy});
      if (tv[i].rst) chk("reset_evt", a_evt, 8'h00);
    end
    b_rst = 1'b0;

    // Glitch: 5 cycles high must be rejected.
    reset_a(1'b0);
    seen_busy = 1'b0; seen_pulse = 1'b0; moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a_din = (i < 5);
      tick();
      seen_busy  |= a_busy;
      seen_pulse |= a_rise | a_fall;
      moved      |= a_dout;
    end
    chk("glitch_dout",  {7'd0, moved},      8'd0);
    chk("glitch_pulse", {7'd0, seen_pulse}, 8'd0);
    chk("glitch_busy_seen", {7'd0, seen_busy}, 8'd1);
    chk("glitch_busy_end",  {7'd0, a_busy},    8'd0);

    // Qualifier: en alternates, commit after 8 qualified samples.
    reset_a(1'b0);
    a_din = 1'b1;
    cnt = 0;
    while (cnt < 40 && !a_dout) begin
      a_en = (cnt % 2 == 0);
      tick();
      cnt++;
    end
    a_en = 1'b1;
    chk("qual_latency_ok", {7'd0, (cnt == 17 || cnt == 18)}, 8'd1);
    if (cnt != 17 && cnt != 18) $display("FAIL qual_latency: got %0d expected 17..18", cnt);

    // Reset on the 4th busy cycle discards the candidate.
    reset_a(1'b0);
    a_din = 1'b1;
    busy_n = 0; cnt = 0;
    while (busy_n < 4 && cnt < 20) begin
      tick();
      cnt++;
      if (a_busy) busy_n++;
    end
    chk("midrst_reached", busy_n[7:0], 8'd4);
    a_rst = 1'b1;
    tick();
    chk("midrst_dout",    {7'd0, a_dout},    8'd0);
    chk("midrst_doutbar", {7'd0, a_doutbar}, 8'd1);
    chk("midrst_busy",    {7'd0, a_busy},    8'd0);
    chk("midrst_rise",    {7'd0, a_rise},    8'd0);
    a_rst = 1'b0;
    cnt = 0;
    while (cnt < 30 && !a_dout) begin
      tick();
      cnt++;
    end
    chk("midrst_requal", cnt[7:0], 8'd10);

    // Fall on B (STABLE_CYCLES=1, reset level 1): dout drops 3 clocks after din.
    b_rst = 1'b1; b_din = 1'b1;
    tick(); tick();
    b_rst = 1'b0;
    tick(); tick();
    chk("fall_pre_dout", {7'd0, b_dout}, 8'd1);
    b_din = 1'b0;
    seen_busy = 1'b0;
    tick(); seen_busy |= b_busy;
    tick(); seen_busy |= b_busy;
    chk("fall_t2_dout", {7'd0, b_dout}, 8'd1);
    tick(); seen_busy |= b_busy;
    chk("fall_t3_dout", {7'd0, b_dout}, 8'd0);
    chk("fall_t3_fall", {7'd0, b_fall}, 8'd1);
    chk("fall_t3_rise", {7'd0, b_rise}, 8'd0);
    tick(); seen_busy |= b_busy;
    chk("fall_t4_fall", {7'd0, b_fall}, 8'd0);
    chk("fall_busy_never", {7'd0, seen_busy}, 8'd0);

    // 257 accepted rising edges on B.
    b_rst = 1'b1; b_din = 1'b1;
    tick();
    b_rst = 1'b0;
    for (int e = 0; e < 257; e++) begin
      b_din = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      b_din = 1'b1;
      for (int k = 0; k < 3; k++) tick();
    end
    tick();
`ifdef DEBOUNCE_EDGE_CNT_EN
    chk("evt_wrap", b_evt, 8'd1);
`else
    chk("evt_tied", b_evt, 8'd0);
`endif

    // Random: held runs of random length, mostly-high qualifier, rare resets.
    for (int i = 0; i < 300; i++) begin
      int len_a;
      logic d_a, d_b;
      len_a = $urandom_range(1, 12);
      d_a   = 1'($urandom_range(0, 1));
      d_b   = 1'($urandom_range(0, 1));
      for (int k = 0; k < len_a; k++) begin
        a_din = d_a;
        a_en  = ($urandom_range(0, 3) != 0);
        a_rst = ($urandom_range(0, 199) == 0);
        b_din = (k < 3) ? d_b : 1'($urandom_range(0, 1));
        b_en  = ($urandom_range(0, 2) != 0);
        b_rst = ($urandom_range(0, 299) == 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
